mod_n_updown_counter: RTL

//  Parametrised synchronous modulo-N up/down counter with enable, sync clear, parallel load and prescaler.

---
 rtl/counter_pkg.sv | 33 +++
 rtl/counter_prescaler.sv | 42 ++++
 rtl/mod_n_updown_counter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared constants, sizing helper and parameter-check macro for the modulo-N counter family.
// The optional COUNTER_SATURATE_EN macro (see mod_n_updown_counter) is not referenced here.

`ifndef COUNTER_PKG_SV
`define COUNTER_PKG_SV

// Elaboration-time guard: instantiate inside a module body with a unique block label.
`define COUNTER_PARAM_CHECK(label, cond) \
  if (!(cond)) begin : label \
    $error("counter: illegal parameter combination"); \
  end

package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Ceiling log2, never less than 1 so a PRESCALE of 1 still gets a one-bit register.
  function automatic int clog2(input longint value);
    int     bits;
    longint rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits = bits + 1;
      rem  = rem >> 1;
    end
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

`endif

// File: rtl/counter_prescaler.sv
// Enable-gated divide-by-PRESCALE tick generator; restart forces the phase back to zero.

module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int PW = clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  `COUNTER_PARAM_CHECK(g_prescale_range, (PRESCALE >= 1) && (PRESCALE <= 65535))

  logic [PW-1:0] cnt_reg;
  logic [PW-1:0] cnt_next;

  assign tick = en && (cnt_reg == LAST);

  always_comb begin
    cnt_next = cnt_reg;
    if (restart) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + PW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/mod_n_updown_counter.sv
// Synchronous modulo-N up/down counter with clear, parallel load and prescaled enable.
// Define COUNTER_SATURATE_EN to hold at the bounds (adds output sat, wrap tied low).

module mod_n_updown_counter
  import counter_pkg::*;
#(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 16,
  parameter int     PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] q,
  output logic             at_term,
  output logic             wrap,
  output logic             load_err
`ifdef COUNTER_SATURATE_EN
  ,
  output logic             sat
`endif
);

  `COUNTER_PARAM_CHECK(g_width_range, (WIDTH >= 1) && (WIDTH <= 32))
  `COUNTER_PARAM_CHECK(g_modulus_range, (MODULUS >= 2) && (MODULUS <= (64'd1 << WIDTH)))

  localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic             tick;
  logic [WIDTH-1:0] q_reg, q_next;
  logic             lerr_reg, lerr_next;
  logic             at_bound;

  counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .en     (en),
    .restart(clear | load),
    .tick   (tick)
  );

  // The bound in the current direction: where an up step wraps or a down step wraps.
  assign at_bound = (up_dn == DIR_UP) ? (q_reg == Q_MAX) : (q_reg == '0);
  assign at_term  = at_bound;
  assign q        = q_reg;
  assign load_err = lerr_reg;

`ifdef COUNTER_SATURATE_EN
  logic sat_reg, sat_next;
  assign sat  = sat_reg;
  assign wrap = 1'b0;

  always_comb begin
    q_next    = q_reg;
    lerr_next = 1'b0;
    sat_next  = sat_reg;
    if (clear) begin
      q_next   = '0;
      sat_next = 1'b0;
    end else if (load) begin
      sat_next = 1'b0;
      if ({1'b0, load_val} >= MOD_EXT) begin
        q_next    = Q_MAX;
        lerr_next = 1'b1;
      end else begin
        q_next = load_val;
      end
    end else if (tick) begin
      if (at_bound) begin
        sat_next = 1'b1;
      end else begin
        q_next   = (up_dn == DIR_UP) ? q_reg + WIDTH'(1) : q_reg - WIDTH'(1);
        sat_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_reg    <= '0;
      lerr_reg <= 1'b0;
      sat_reg  <= 1'b0;
    end else begin
      q_reg    <= q_next;
      lerr_reg <= lerr_next;
      sat_reg  <= sat_next;
    end
  end
`else
  logic wrap_reg, wrap_next;
  assign wrap = wrap_reg;

  always_comb begin
    q_next    = q_reg;
    lerr_next = 1'b0;
    wrap_next = 1'b0;
    if (clear) begin
      q_next = '0;
    end else if (load) begin
      if ({1'b0, load_val} >= MOD_EXT) begin
        q_next    = Q_MAX;
        lerr_next = 1'b1;
      end else begin
        q_next = load_val;
      end
    end else if (tick) begin
      // At the bound the step jumps to the opposite end instead of incrementing.
      if (at_bound) begin
        q_next    = (up_dn == DIR_UP) ? '0 : Q_MAX;
        wrap_next = 1'b1;
      end else begin
        q_next = (up_dn == DIR_UP) ? q_reg + WIDTH'(1) : q_reg - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_reg    <= '0;
      lerr_reg <= 1'b0;
      wrap_reg <= 1'b0;
    end else begin
      q_reg    <= q_next;
      lerr_reg <= lerr_next;
      wrap_reg <= wrap_next;
    end
  end
`endif

endmodule
